abus_arbiter: RTL and testbench
===============================

# abus_arbiter

Shares the 16-bit A-bus between several datapath requesters (ALU operand fetch, address generator, pixel loader). It drives the A-bus source-select code `a_flag` consumed by the A-bus source mux. Each requester names the register it wants on the bus (PC, DR, R1–R5). The arbiter grants one requester at a time with round-robin fairness and holds the grant until the requester releases it. While no requester holds a grant, `a_flag` is 0 and the bus floats.

## Interface

Parameters:
- `NREQ`, default 3: number of requesters, 2..8.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles. Used only when the timeout feature is compiled in; minimum 2.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: synchronous reset, active-low.
- `req`, input, NREQ: request per requester, level-held for the whole transfer.
- `src_sel`, input, 3*NREQ: per-requester source code; bits [3i+2:3i] belong to requester i. Codes: 1=PC, 2=DR, 3..7=R1..R5.
- `gnt`, output, NREQ: one-hot grant, registered.
- `a_flag`, output, 3: A-bus source select, registered; 0 means released.
- `busy`, output, 1: high while any grant is active.
- `timeout`, output, NREQ: one-cycle pulse on forced release. Present only with `ABUS_ARB_TIMEOUT_EN`.

## Operation

- States: IDLE and GRANT.
- IDLE outputs: `gnt`=0, `a_flag`=0, `busy`=0.
- Eligibility: requester i is eligible when `req[i]`=1, its `src_sel` code ≠ 0, and its mask bit is clear.
- Code 0: a requester presenting code 0 is ignored for arbitration and is never granted.
- IDLE → GRANT: taken when any requester is eligible.
  - The winner is the first eligible index strictly after `last_ptr`, wrapping modulo NREQ.
  - `last_ptr` updates to the winner.
  - The winner's `src_sel` is latched into `a_flag`. Changes to `src_sel` during the grant are ignored.
- GRANT → IDLE: taken when `req[winner]` is sampled low. The bus is released for exactly one cycle, which is the turnaround, and arbitration runs in that IDLE cycle.
- Requests from other requesters during GRANT have no effect until IDLE.
- Reset values:
  - state = IDLE.
  - All outputs = 0.
  - `last_ptr` = NREQ-1, so requester 0 has first priority.
  - Mask bits and hold counter = 0.

## Timing

- Grant latency: `req` sampled high in IDLE at edge n gives `gnt`/`a_flag` valid from edge n+1.
- Release: `req` sampled low in GRANT at edge m gives `gnt`=0 and `a_flag`=0 from edge m+1. The earliest next grant is at edge m+2.
- Minimum grant length is 1 cycle. Back-to-back transfers always have one idle cycle between them.
- Simultaneous requests in IDLE: resolved by the round-robin order only; there is no fixed priority after the first grant.
- Reset mid-grant: `rst_n` sampled low forces all outputs to 0 at that edge regardless of state. Pointer, masks and counter return to their reset values.

## Configuration

- Macro: `ABUS_ARB_TIMEOUT_EN`.
- When defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter reaches MAX_HOLD with `req[winner]` still high, the next edge forces IDLE, pulses `timeout[winner]` for one cycle, and sets `mask[winner]`.
  - `mask[i]` clears on the first cycle `req[i]` is sampled low.
  - A masked requester is not eligible.
- When undefined:
  - The counter, masks and `timeout` port are absent.
  - A grant lasts until `req` drops, with no upper bound.

## Structure

- Shared package `abus_pkg` holds:
  - source code constants `SRC_NONE`=0, `SRC_PC`=1, `SRC_DR`=2, `SRC_R1`..`SRC_R5`=3..7;
  - the state enum (IDLE, GRANT).
- One sub-module, `rr_picker`: a combinational round-robin priority encoder. Inputs are the eligible vector and `last_ptr`; outputs are a valid flag and the winner index.
- Registers and the FSM stay in `abus_arbiter`.

## Test plan

1. Reset: hold `rst_n`=0 for 2 cycles with `req` all ones → `gnt`=0, `a_flag`=0 and `busy`=0 throughout; first grant afterwards goes to requester 0.
2. Single transfer: `req`=001 with `src_sel[0]`=1 at edge 0, held for 4 cycles → `gnt`=001 and `a_flag`=1 on edges 1–4, `a_flag`=0 on edge 5. Changing `src_sel[0]` to 5 at edge 2 leaves `a_flag`=1.
3. Round-robin: `req`=111 continuously, codes 2/3/4, each requester dropping `req` after 1 granted cycle and reasserting → grant order 0,1,2,0 with `a_flag` sequence 2,0,3,0,4,0,2.
4. Invalid code: `req`=010 with `src_sel[1]`=0 for 10 cycles → no grant and `a_flag`=0. Then `req[2]` with code 7 → `gnt`=100 and `a_flag`=7 one cycle later.
5. Timeout (macro on, MAX_HOLD=4): `req[0]` held high with `req[2]` pending.
   - `gnt[0]` stays high for 4 cycles, then IDLE with `timeout[0]` pulsing for 1 cycle.
   - `gnt[2]` follows on the next edge.
   - Requester 0 is not regranted until it drops `req`.
   - With the macro off, `gnt[0]` stays high indefinitely.
6. Reset mid-grant: `rst_n`=0 during GRANT with `a_flag`=6 → outputs 0 at that edge; after release, `req`=011 grants requester 0 first.

Source files
------------

// File: rtl/abus_pkg.sv
// abus_pkg: A-bus source codes and arbiter state encoding shared by the arbiter files.
package abus_pkg;
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_PC   = 3'd1;
    localparam logic [2:0] SRC_DR   = 3'd2;
    localparam logic [2:0] SRC_R1   = 3'd3;
    localparam logic [2:0] SRC_R2   = 3'd4;
    localparam logic [2:0] SRC_R3   = 3'd5;
    localparam logic [2:0] SRC_R4   = 3'd6;
    localparam logic [2:0] SRC_R5   = 3'd7;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/abus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin encoder picking the first eligible index after last_ptr.
//   elig     : eligible requesters
//   last_ptr : index of the previous winner
//   valid    : some requester is eligible
//   win      : chosen index (wraps modulo NREQ)
module rr_picker import abus_pkg::*; #(
    parameter int NREQ = 3,
    parameter int W    = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [W-1:0]    last_ptr,
    output logic            valid,
    output logic [W-1:0]    win
);
    logic [W-1:0] idx;
    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        valid = 1'b0;
        win = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = W'((int'(last_ptr) + k) % NREQ);
            if (elig[idx]) begin
                valid = 1'b1;
                win = idx;
            end
        end
    end
endmodule

// File: rtl/abus_arbiter.sv
// abus_arbiter: round-robin A-bus arbiter that latches the winner's source code onto a_flag.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-requester level request
//   src_sel    : per-requester 3-bit source code, requester i at [3i+2:3i]
//   gnt        : registered one-hot grant
//   a_flag     : registered A-bus source select, 0 when released
//   busy       : a grant is active
//   timeout    : forced-release pulse, only with ABUS_ARB_TIMEOUT_EN defined
module abus_arbiter import abus_pkg::*; #(
    parameter int NREQ     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    src_sel,
    output logic [NREQ-1:0]      gnt,
    output logic [2:0]           a_flag,
    output logic                 busy
`ifdef ABUS_ARB_TIMEOUT_EN
    ,
    output logic [NREQ-1:0]      timeout
`endif
);
    localparam int W = $clog2(NREQ);
    if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 2) begin : g_bad_param
        $error("abus_arbiter: NREQ must be 2..8 and MAX_HOLD at least 2");
    end
    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      a_flag_q, a_flag_d;
    logic [W-1:0]    last_q, last_d;
    logic [2:0]      code [NREQ];
    logic [NREQ-1:0] elig, mask;
    logic            pick_valid, hold_exp;
    logic [W-1:0]    pick_win;
    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign code[i] = src_sel[3*i +: 3];
        assign elig[i] = req[i] & (code[i] != SRC_NONE) & ~mask[i];
    end
    rr_picker #(.NREQ(NREQ), .W(W)) u_pick (
        .elig(elig),
        .last_ptr(last_q),
        .valid(pick_valid),
        .win(pick_win)
    );
`ifdef ABUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] mask_q, mask_d, tmo_q, tmo_d;
    assign hold_exp = cnt_q == CW'(MAX_HOLD - 1);
    assign mask = mask_q;
    assign timeout = tmo_q;
    // The counter sits at 0 in IDLE, so each grant starts counting from zero.
    always_comb begin
        cnt_d = state_q == IDLE ? '0 : cnt_q + 1'b1;
        tmo_d = (state_q == GRANT && req[last_q] && hold_exp) ? gnt_q : '0;
        mask_d = (mask_q & req) | tmo_d;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mask_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            mask_q <= mask_d;
            tmo_q <= tmo_d;
        end
    end
`else
    assign hold_exp = 1'b0;
    assign mask = '0;
`endif
    // last_q doubles as the current winner while in GRANT.
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        a_flag_d = a_flag_q;
        last_d = last_q;
        if (state_q == IDLE) begin
            if (pick_valid) begin
                state_d = GRANT;
                gnt_d = NREQ'(1) << pick_win;
                a_flag_d = code[pick_win];
                last_d = pick_win;
            end
        end else if (!req[last_q] || hold_exp) begin
            state_d = IDLE;
            gnt_d = '0;
            a_flag_d = SRC_NONE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q <= '0;
            a_flag_q <= SRC_NONE;
            last_q <= W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            a_flag_q <= a_flag_d;
            last_q <= last_d;
        end
    end
    assign gnt = gnt_q;
    assign a_flag = a_flag_q;
    assign busy = state_q == GRANT;
endmodule

// File: tb/tb_abus_arbiter.sv
// tb_abus_arbiter: scoreboard bench for abus_arbiter with NREQ=3, MAX_HOLD=4.
module tb_abus_arbiter;
    typedef struct {
        logic [2:0] g;
        logic [2:0] f;
        logic       b;
        logic [2:0] t;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [8:0] src_sel;
    logic [2:0] gnt;
    logic [2:0] a_flag;
    logic       busy;
`ifdef ABUS_ARB_TIMEOUT_EN
    logic [2:0] timeout;
`endif
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    abus_arbiter #(.NREQ(3), .MAX_HOLD(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .src_sel(src_sel),
        .gnt(gnt),
        .a_flag(a_flag),
        .busy(busy)
`ifdef ABUS_ARB_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );
    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        req = 3'b111;
        src_sel = {3'd3, 3'd2, 3'd1};
        for (int c = 0; c < 5; c++) begin
            if (c == 2) rst_n = 1'b1;
            if (c == 3) req = 3'b000;
            sb.push_back(c == 2 ? exp_t'{3'b001, 3'd1, 1'b1, 3'b000} : exp_t'{3'b000, 3'd0, 1'b0, 3'b000});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, a_flag, busy} !== {e.g, e.f, e.b}) begin
                errors++;
                $display("FAIL reset c%0d: gnt=%b a_flag=%0d busy=%b, expected gnt=%b a_flag=%0d busy=%b", c, gnt, a_flag, busy, e.g, e.f, e.b);
            end
        end
    endtask
    task automatic test_single();
        exp_t e;
        src_sel = {3'd0, 3'd0, 3'd1};
        for (int c = 0; c < 6; c++) begin
            req = c < 4 ? 3'b001 : 3'b000;
            if (c >= 1) src_sel[2:0] = 3'd5;
            sb.push_back(c < 4 ? exp_t'{3'b001, 3'd1, 1'b1, 3'b000} : exp_t'{3'b000, 3'd0, 1'b0, 3'b000});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, a_flag, busy} !== {e.g, e.f, e.b}) begin
                errors++;
                $display("FAIL single c%0d: gnt=%b a_flag=%0d busy=%b, expected gnt=%b a_flag=%0d busy=%b", c, gnt, a_flag, busy, e.g, e.f, e.b);
            end
        end
    endtask
    task automatic test_round_robin();
        exp_t e;
        logic [2:0] rq [9] = '{3'b000, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b111, 3'b110};
        logic [2:0] eg [9] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        logic [2:0] ef [9] = '{3'd0, 3'd2, 3'd0, 3'd3, 3'd0, 3'd4, 3'd0, 3'd2, 3'd0};
        src_sel = {3'd4, 3'd3, 3'd2};
        for (int c = 0; c < 9; c++) begin
            rst_n = c != 0;
            req = rq[c];
            sb.push_back(exp_t'{eg[c], ef[c], eg[c] != 3'b000, 3'b000});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, a_flag, busy} !== {e.g, e.f, e.b}) begin
                errors++;
                $display("FAIL round_robin c%0d: gnt=%b a_flag=%0d busy=%b, expected gnt=%b a_flag=%0d busy=%b", c, gnt, a_flag, busy, e.g, e.f, e.b);
            end
        end
        req = 3'b000;
        @(posedge clk); #1;
    endtask
    task automatic test_invalid_code();
        exp_t e;
        src_sel = {3'd7, 3'd0, 3'd2};
        for (int c = 0; c < 12; c++) begin
            req = c < 10 ? 3'b010 : (c == 10 ? 3'b110 : 3'b000);
            sb.push_back(c == 10 ? exp_t'{3'b100, 3'd7, 1'b1, 3'b000} : exp_t'{3'b000, 3'd0, 1'b0, 3'b000});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, a_flag, busy} !== {e.g, e.f, e.b}) begin
                errors++;
                $display("FAIL invalid_code c%0d: gnt=%b a_flag=%0d busy=%b, expected gnt=%b a_flag=%0d busy=%b", c, gnt, a_flag, busy, e.g, e.f, e.b);
            end
        end
    endtask
`ifdef ABUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        logic [2:0] rq [13] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000};
        logic [2:0] eg [13] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        logic [2:0] ef [13] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
        src_sel = {3'd6, 3'd0, 3'd1};
        rst_n = 1'b0;
        req = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 13; c++) begin
            req = rq[c];
            sb.push_back(exp_t'{eg[c], ef[c], eg[c] != 3'b000, c == 4 ? 3'b001 : 3'b000});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, a_flag, busy, timeout} !== {e.g, e.f, e.b, e.t}) begin
                errors++;
                $display("FAIL timeout c%0d: gnt=%b a_flag=%0d busy=%b timeout=%b, expected gnt=%b a_flag=%0d busy=%b timeout=%b", c, gnt, a_flag, busy, timeout, e.g, e.f, e.b, e.t);
            end
        end
    endtask
`else
    task automatic test_timeout();
        exp_t e;
        src_sel = {3'd6, 3'd0, 3'd1};
        rst_n = 1'b0;
        req = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 24; c++) begin
            req = c < 20 ? 3'b101 : (c < 22 ? 3'b100 : 3'b000);
            sb.push_back(c < 20 ? exp_t'{3'b001, 3'd1, 1'b1, 3'b000} : (c == 21 ? exp_t'{3'b100, 3'd6, 1'b1, 3'b000} : exp_t'{3'b000, 3'd0, 1'b0, 3'b000}));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, a_flag, busy} !== {e.g, e.f, e.b}) begin
                errors++;
                $display("FAIL long_hold c%0d: gnt=%b a_flag=%0d busy=%b, expected gnt=%b a_flag=%0d busy=%b", c, gnt, a_flag, busy, e.g, e.f, e.b);
            end
        end
    endtask
`endif
    task automatic test_reset_mid_grant();
        exp_t e;
        logic [2:0] rq [7] = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b010, 3'b010, 3'b000};
        logic [2:0] eg [7] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
        logic [2:0] ef [7] = '{3'd6, 3'd6, 3'd0, 3'd6, 3'd0, 3'd3, 3'd0};
        src_sel = {3'd5, 3'd3, 3'd6};
        for (int c = 0; c < 7; c++) begin
            rst_n = c != 2;
            req = rq[c];
            sb.push_back(exp_t'{eg[c], ef[c], eg[c] != 3'b000, 3'b000});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, a_flag, busy} !== {e.g, e.f, e.b}) begin
                errors++;
                $display("FAIL reset_mid_grant c%0d: gnt=%b a_flag=%0d busy=%b, expected gnt=%b a_flag=%0d busy=%b", c, gnt, a_flag, busy, e.g, e.f, e.b);
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_invalid_code();
        test_timeout();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
